// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: handshaked access FSM with wait states, inferred RAM,
// memory-mapped LED/switch registers and a sticky bus-error flag.
module mem_bus_ctrl #(
  parameter int              DW          = 16,
  parameter int              AW          = 9,
  parameter int              RAM_AW      = 8,
  parameter int              IO_W        = 8,
  parameter int              WAIT_STATES = 1,
  parameter logic [AW-1:0]   LED_ADDR    = 'h100,
  parameter logic [AW-1:0]   SW_ADDR     = 'h140
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mem_cmd,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   write_data,
  output logic [DW-1:0]   read_data,
  output logic            mem_ready,
  input  logic [IO_W-1:0] sw_in,
  output logic [IO_W-1:0] led_out,
  input  logic            err_clr,
  output logic            bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILL   = 2'b11;
  localparam logic [3:0] WS_M1  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [1:0]      cmd_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            ready_q;
  logic [DW-1:0]   rdata_q;
  logic [IO_W-1:0] led_q;
  logic [IO_W-1:0] sw_s1_q;
  logic [IO_W-1:0] sw_s2_q;
  logic            err_q;
  logic [DW-1:0]   mem_q [2**RAM_AW];

  logic [1:0]      acc_cmd;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_data;
  logic            commit;
  logic            is_ram, is_led, is_sw;
  logic            err_d;
  logic [DW-1:0]   rdata_d;

  // With zero wait states the commit edge is the IDLE edge, so decode the live inputs.
  always_comb begin
    acc_cmd  = cmd_q;
    acc_addr = addr_q;
    acc_data = wdata_q;
    commit   = 1'b0;
    if (state_q == S_IDLE) begin
      acc_cmd  = mem_cmd;
      acc_addr = mem_addr;
      acc_data = write_data;
      commit   = (WAIT_STATES == 0) && (mem_cmd != MNONE);
    end else if (state_q == S_ACCESS) begin
      commit   = (cnt_q == 4'd0);
    end
  end

  always_comb begin
    is_ram  = ~acc_addr[AW-1];
    is_led  = (acc_addr == LED_ADDR);
    is_sw   = (acc_addr == SW_ADDR);
    err_d   = (acc_cmd == MILL) || (!is_ram && !is_led && !is_sw) ||
              (is_sw && acc_cmd == MWRITE);
    rdata_d = '0;
    if (acc_cmd == MREAD) begin
      if (is_ram)      rdata_d = mem_q[acc_addr[RAM_AW-1:0]];
      else if (is_led) rdata_d = DW'(led_q);
      else if (is_sw)  rdata_d = DW'(sw_s2_q);
    end
  end

  // RAM is never reset; a reset on the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (reset && commit && is_ram && acc_cmd == MWRITE)
      mem_q[acc_addr[RAM_AW-1:0]] <= acc_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      led_q   <= '0;
      err_q   <= 1'b0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
      ready_q <= commit;
      rdata_q <= commit ? rdata_d : '0;
      if (commit && err_d)   err_q <= 1'b1;
      else if (err_clr)      err_q <= 1'b0;
      if (commit && is_led && acc_cmd == MWRITE)
        led_q <= acc_data[IO_W-1:0];
      case (state_q)
        S_IDLE: begin
          if (mem_cmd != MNONE) begin
            cmd_q   <= mem_cmd;
            addr_q  <= mem_addr;
            wdata_q <= write_data;
            cnt_q   <= WS_M1;
            state_q <= (WAIT_STATES > 0) ? S_ACCESS : S_RESP;
          end
        end
        S_ACCESS: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data = rdata_q;
  assign mem_ready = ready_q;
  assign led_out   = led_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: three instances (default, 3 wait states,
// 0 wait states with a 7-bit RAM index) driven through one muxed stimulus port.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_g, reset, err_clr;
  int          sel;
  logic [1:0]  cmd;
  logic [8:0]  addr;
  logic [15:0] wdata;
  logic [7:0]  sw;

  logic        rdy_v [3];
  logic [15:0] rd_v  [3];
  logic [7:0]  led_v [3];
  logic        err_v [3];
  logic [1:0]  cmd_v [3];
  logic        rst_v [3];
  logic        clr_v [3];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cmd_v[k] = (sel == k) ? cmd : 2'b00;
      rst_v[k] = reset_g & ((sel == k) ? reset : 1'b1);
      clr_v[k] = (sel == k) & err_clr;
    end
  end

  logic        rdy, err;
  logic [15:0] rd;
  logic [7:0]  led;
  assign rdy = rdy_v[sel];
  assign rd  = rd_v[sel];
  assign led = led_v[sel];
  assign err = err_v[sel];

  mem_bus_ctrl u_def (
    .clk(clk), .reset(rst_v[0]), .mem_cmd(cmd_v[0]), .mem_addr(addr),
    .write_data(wdata), .read_data(rd_v[0]), .mem_ready(rdy_v[0]),
    .sw_in(sw), .led_out(led_v[0]), .err_clr(clr_v[0]), .bus_err(err_v[0]));

  mem_bus_ctrl #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst_v[1]), .mem_cmd(cmd_v[1]), .mem_addr(addr),
    .write_data(wdata), .read_data(rd_v[1]), .mem_ready(rdy_v[1]),
    .sw_in(sw), .led_out(led_v[1]), .err_clr(clr_v[1]), .bus_err(err_v[1]));

  mem_bus_ctrl #(.WAIT_STATES(0), .RAM_AW(7)) u_ws0 (
    .clk(clk), .reset(rst_v[2]), .mem_cmd(cmd_v[2]), .mem_addr(addr),
    .write_data(wdata), .read_data(rd_v[2]), .mem_ready(rdy_v[2]),
    .sw_in(sw), .led_out(led_v[2]), .err_clr(clr_v[2]), .bus_err(err_v[2]));

  typedef struct {
    int          sel;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic [7:0]  exp_led;
    logic        exp_err;
    logic        clr_late;
    logic        sw_en;
    logic [7:0]  sw_new;
  } vec_t;

  vec_t tbl [14];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; that cycle is cycle 0 of the access.
  task automatic run_vec(input int i);
    vec_t v;
    int   k;
    bit   got;
    v     = tbl[i];
    sel   = v.sel;
    cmd   = v.cmd;
    addr  = v.addr;
    wdata = v.wdata;
    k     = 0;
    got   = 0;
    while (!got && k < 20) begin
      if (k == v.lat - 1) begin
        err_clr = v.clr_late;
        if (v.sw_en) sw = v.sw_new;
      end
      @(negedge clk);
      if (rdy) got = 1;
      else begin
        chk($sformatf("v%0d_rd_idle_c%0d", i, k), 32'(rd), 32'h0);
        @(posedge clk); #1;
        err_clr = 1'b0;
        k++;
      end
    end
    cmd = 2'b00;
    chk($sformatf("v%0d_latency", i), 32'(k), 32'(v.lat));
    if (v.chk_rd) chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(v.exp_rd));
    chk($sformatf("v%0d_led", i), 32'(led), 32'(v.exp_led));
    chk($sformatf("v%0d_bus_err", i), 32'(err), 32'(v.exp_err));
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk($sformatf("v%0d_ready_drop", i), 32'(rdy), 32'h0);
    chk($sformatf("v%0d_rd_drop", i), 32'(rd), 32'h0);
  endtask

  initial begin
    tbl[0]  = '{0, 2'b10, 9'h005, 16'hBEEF, 2, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{0, 2'b01, 9'h005, 16'h0000, 2, 1'b1, 16'hBEEF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{0, 2'b10, 9'h100, 16'h12A5, 2, 1'b0, 16'h0000, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{0, 2'b01, 9'h100, 16'h0000, 2, 1'b1, 16'h00A5, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{0, 2'b01, 9'h140, 16'h0000, 2, 1'b1, 16'h003C, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hFF};
    tbl[5]  = '{0, 2'b01, 9'h140, 16'h0000, 2, 1'b1, 16'h00FF, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{0, 2'b01, 9'h1F0, 16'h0000, 2, 1'b1, 16'h0000, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{0, 2'b10, 9'h140, 16'h1234, 2, 1'b0, 16'h0000, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{0, 2'b11, 9'h005, 16'h5555, 2, 1'b1, 16'h0000, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{0, 2'b01, 9'h005, 16'h0000, 2, 1'b1, 16'hBEEF, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{2, 2'b10, 9'h025, 16'hCAFE, 1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{2, 2'b01, 9'h0A5, 16'h0000, 1, 1'b1, 16'hCAFE, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1, 2'b10, 9'h010, 16'h1111, 4, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1, 2'b01, 9'h010, 16'h0000, 4, 1'b1, 16'h1111, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

    reset_g = 1'b0; reset = 1'b1; sel = 0; cmd = 2'b00; addr = '0;
    wdata = '0; sw = 8'h3C; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_g = 1'b1;

    for (int k = 0; k < 3; k++) begin
      sel = k;
      @(negedge clk);
      chk($sformatf("rst%0d_ready", k), 32'(rdy), 32'h0);
      chk($sformatf("rst%0d_rdata", k), 32'(rd), 32'h0);
      chk($sformatf("rst%0d_led", k), 32'(led), 32'h0);
      chk($sformatf("rst%0d_bus_err", k), 32'(err), 32'h0);
    end
    @(posedge clk); #1;

    for (int i = 0; i <= 7; i++) run_vec(i);

    // err_clr on its own clears the sticky flag
    sel = 0; err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr_alone", 32'(err), 32'h0);
    @(posedge clk); #1;

    for (int i = 8; i <= 9; i++) run_vec(i);

    // one-cycle reset clears LED and bus_err
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_bus_err", 32'(err), 32'h0);
    chk("rst_ready", 32'(rdy), 32'h0);
    @(posedge clk); #1;

    for (int i = 10; i <= 12; i++) run_vec(i);

    // aborted write: reset asserted in cycle 2 of a 3-wait-state access
    sel = 1; cmd = 2'b10; addr = 9'h010; wdata = 16'h2222;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0; cmd = 2'b00;
    @(posedge clk); #1 reset = 1'b1;
    for (int c = 3; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("abort_ready_c%0d", c), 32'(rdy), 32'h0);
      chk($sformatf("abort_rdata_c%0d", c), 32'(rd), 32'h0);
      @(posedge clk); #1;
    end

    run_vec(13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

- Parametrised memory-bus controller between the `cpu` memory port (`mem_cmd`, `mem_addr`, `write_data`, `read_data`) and the board.
- Replaces the ad-hoc tri-state RAM hookup with:
  - a registered, handshaked access FSM with configurable wait states;
  - an internal inferred RAM;
  - memory-mapped LED and switch registers;
  - a sticky bus-error flag for unmapped or illegal accesses.
- Sits directly inside the top level, one instance per CPU.

## Interface

Parameters:
- DW, 16, data width of `write_data`/`read_data`
- AW, 9, width of `mem_addr`
- RAM_AW, 8, RAM index width; depth = 2**RAM_AW; must be ≤ AW-1
- IO_W, 8, width of `sw_in` and `led_out`; must be ≤ DW
- WAIT_STATES, 1, extra access cycles before response, legal range 0..15
- LED_ADDR, 9'h100, address of the LED register
- SW_ADDR, 9'h140, address of the switch register

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (reset==0 resets on next rising clk edge)
- mem_cmd  in  2  2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 illegal
- mem_addr  in  AW  byte-free word address
- write_data  in  DW  store data
- read_data  out  DW  load data; valid only while mem_ready=1, else 0
- mem_ready  out  1  one-cycle pulse: access complete
- sw_in  in  IO_W  asynchronous board switches
- led_out  out  IO_W  LED register
- err_clr  in  1  clears bus_err
- bus_err  out  1  sticky error flag

## Operation

FSM states:
- IDLE:
  - If mem_cmd≠00, latch cmd, addr and data.
  - Go to ACCESS if WAIT_STATES>0, else RESP.
- ACCESS:
  - Wait counter (4 bits) loaded with WAIT_STATES-1; decrements each cycle.
  - At 0, go to RESP.
- RESP:
  - mem_ready=1 and read_data driven for exactly this cycle.
  - mem_cmd is ignored this cycle; always return to IDLE.
  - The CPU must drop or change mem_cmd after seeing mem_ready. A command still held in the IDLE cycle after RESP starts a new access.
- Commit point: the clock edge that enters RESP.
  - RAM write, LED update and bus_err set happen on this edge.
  - RAM read data and switch value are captured into the read_data register on this edge.

Address decode uses the latched address:
- addr[AW-1]==0: RAM.
  - Index = addr[RAM_AW-1:0]; upper index bits are ignored, so aliasing is intended.
- addr==LED_ADDR:
  - Write: led_out ← write_data[IO_W-1:0].
  - Read: returns led_out zero-extended.
- addr==SW_ADDR:
  - Read: returns synchronised switches zero-extended.
  - Write: ignored, sets bus_err.
- Any other address with addr[AW-1]==1: access ignored, reads return 0, sets bus_err.
- mem_cmd=11: no side effects, read_data=0, sets bus_err, still completes with mem_ready.

Switch synchroniser:
- sw_in passes through a 2-flop synchroniser that runs every cycle, independent of the FSM.
- A read returns the second-stage value at the commit edge.

bus_err:
- Set at commit of an erroring access.
- Cleared when err_clr=1.
- If err_clr=1 and an error is committed on the same edge, set wins.

Reset (reset==0 at a rising edge), whatever the state:
- FSM→IDLE, wait counter→0, mem_ready→0, read_data→0, led_out→0, bus_err→0, synchroniser flops→0.
- An access whose commit edge has not occurred is aborted with no RAM/LED write.
- RAM contents are not reset.

## Timing

- Command first presented in IDLE during cycle 0 → mem_ready=1 in cycle WAIT_STATES+1.
  - WAIT_STATES=0: cycle 1. Default WAIT_STATES=1: cycle 2.
- Throughput: one access per WAIT_STATES+2 cycles when back-to-back (RESP cycle is not overlapped).
- mem_ready, read_data, led_out and bus_err are all registered outputs; no combinational path from any input.
- Switch change → visible to reads after 2 clk edges.
- Read of a RAM word written by the immediately preceding access returns the new data; the write has committed before the next IDLE.

## Test plan

- Defaults:
  - MWRITE addr 9'h005 data 16'hBEEF held until ready → mem_ready pulse in cycle 2.
  - Then MREAD 9'h005 → read_data=16'hBEEF during ready cycle, 0 otherwise.
  - MREAD 9'h0A5 with RAM_AW=7 aliases to index 9'h025.
- MWRITE 9'h100 data 16'h12A5 → led_out=8'hA5 from commit edge.
  - MREAD 9'h100 → read_data=16'h00A5.
  - bus_err stays 0.
- sw_in=8'h3C stable ≥2 cycles, MREAD 9'h140 → read_data=16'h003C.
  - sw_in changed to 8'hFF one cycle before the commit edge → still reads 16'h003C.
- MREAD 9'h1F0 → read_data=0, mem_ready pulses, bus_err=1 and held.
  - Simultaneous err_clr=1 with an MWRITE to 9'h140 → bus_err remains 1.
  - Then err_clr alone → bus_err=0.
  - mem_cmd=11 → bus_err=1.
- WAIT_STATES=3:
  - MWRITE 9'h010 data 16'h1111 → mem_ready in cycle 4.
  - Second MWRITE 9'h010 data 16'h2222, with reset=0 asserted in cycle 2 → FSM IDLE, outputs 0.
  - Later MREAD 9'h010 → 16'h1111.
- Reset=0 held for 1 cycle with led_out=8'hA5, bus_err=1 → both 0 after the edge. Then WAIT_STATES=0 read completes with mem_ready in cycle 1.
